// File: rtl/alu_input_pkg.sv
// Shared types and defaults for the ALU input conditioner.
// Holds the chord FSM encoding and the debounce length.
package alu_input_pkg;

  localparam int DB_CYCLES_DEF = 50000;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    COMMIT
  } state_t;

endpackage

// File: rtl/debounce_cell.sv
// Single-bit debouncer: the level flips only after DB_CYCLES
// consecutive cycles of disagreement with the synced input.
import alu_input_pkg::*;

module debounce_cell #(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt;

  // cnt tops out at LAST; the >= compare keeps it from wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (din == level) begin
      cnt <= '0;
    end else if (cnt >= LAST) begin
      level <= ~level;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_input_conditioner.sv
// Turns raw buttons/switches into a committed ALU opcode and
// operand pair, one strobe per released button chord.
import alu_input_pkg::*;

module alu_input_conditioner #(
  parameter int WIDTH     = 4,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       BtnUC,
  input  logic [WIDTH-1:0] SwA,
  input  logic [WIDTH-1:0] SwB,
  output logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             op_strobe
);

  logic [2:0]       btn_s1, btn_s2;
  logic [WIDTH-1:0] swa_s1, swa_s2;
  logic [WIDTH-1:0] swb_s1, swb_s2;
  logic [2:0]       deb;

  state_t     state, state_nxt;
  logic [2:0] chord, chord_nxt;

  // buttons are active-low on the board; flip to 1 = pressed
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      swa_s1 <= '0;
      swa_s2 <= '0;
      swb_s1 <= '0;
      swb_s2 <= '0;
    end else begin
      btn_s1 <= ~BtnUC;
      btn_s2 <= btn_s1;
      swa_s1 <= SwA;
      swa_s2 <= swa_s1;
      swb_s1 <= SwB;
      swb_s2 <= swb_s1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_db
    debounce_cell #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .din  (btn_s2[i]),
      .level(deb[i])
    );
  end

  always_comb begin
    state_nxt = state;
    chord_nxt = chord;
    unique case (state)
      IDLE: begin
        if (|deb) begin
          state_nxt = COLLECT;
          chord_nxt = deb;
        end
      end
      COLLECT: begin
        chord_nxt = chord | deb;
        if (deb == 3'b000) state_nxt = COMMIT;
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      chord <= '0;
    end else begin
      state <= state_nxt;
      chord <= chord_nxt;
    end
  end

  assign op_strobe = (state == COMMIT);

  // outputs only move on the commit edge, so they hold otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      ALUControl <= '0;
      A          <= '0;
      B          <= '0;
    end else if (state == COMMIT) begin
      ALUControl <= chord;
      A          <= swa_s2;
      B          <= swb_s2;
    end
  end

endmodule

// File: tb/tb_alu_input_conditioner.sv
// Self-checking bench for alu_input_conditioner (DB_CYCLES=4).
// Directed scenarios plus randomized chords against a timing model.
module tb_alu_input_conditioner;

  localparam int DB  = 4;
  localparam int W   = 4;
  localparam int LAT = 2 + DB + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   BtnUC;
  logic [W-1:0] SwA, SwB;
  logic [2:0]   ALUControl;
  logic [W-1:0] A, B;
  logic         op_strobe;

  alu_input_conditioner #(
    .WIDTH    (W),
    .DB_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .BtnUC     (BtnUC),
    .SwA       (SwA),
    .SwB       (SwB),
    .ALUControl(ALUControl),
    .A         (A),
    .B         (B),
    .op_strobe (op_strobe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_strobe = 0;
  int last_strobe = -1;
  always @(negedge clk) begin
    if (op_strobe === 1'b1) begin
      n_strobe++;
      last_strobe = cyc;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: a button counts toward the chord iff its raw press lasts
  // at least DB cycles; strobe comes LAT cycles after the last such
  // release, and the outputs then reflect chord and switch values.
  task automatic run_pattern(input string tag,
                             input int s0, input int e0,
                             input int s1, input int e1,
                             input int s2, input int e2,
                             input logic [W-1:0] sa,
                             input logic [W-1:0] sb);
    int ps[3];
    int pe[3];
    int last_rel, all_end, rel_cyc, n0, total;
    logic [2:0]   exp_mask;
    logic [2:0]   old_alu;
    logic [W-1:0] old_a, old_b;
    ps[0] = s0; pe[0] = e0;
    ps[1] = s1; pe[1] = e1;
    ps[2] = s2; pe[2] = e2;
    exp_mask = '0;
    last_rel = 0;
    all_end  = 0;
    rel_cyc  = 0;
    for (int i = 0; i < 3; i++) begin
      if (pe[i] - ps[i] >= DB) begin
        exp_mask[i] = 1'b1;
        if (pe[i] > last_rel) last_rel = pe[i];
      end
      if (pe[i] > all_end) all_end = pe[i];
    end
    old_alu = ALUControl;
    old_a   = A;
    old_b   = B;
    n0      = n_strobe;
    SwA     = sa;
    SwB     = sb;
    total   = all_end + LAT + 6;
    for (int c = 0; c < total; c++) begin
      for (int i = 0; i < 3; i++)
        BtnUC[i] = !(c >= ps[i] && c < pe[i]);
      if (c == last_rel) rel_cyc = cyc;
      step(1);
    end
    if (exp_mask != 3'b000) begin
      check({tag, ".strobes"}, n_strobe - n0, 1);
      check({tag, ".latency"}, last_strobe - rel_cyc, LAT);
      check({tag, ".alu"}, ALUControl, exp_mask);
      check({tag, ".a"}, A, sa);
      check({tag, ".b"}, B, sb);
    end else begin
      check({tag, ".strobes"}, n_strobe - n0, 0);
      check({tag, ".alu_hold"}, ALUControl, old_alu);
      check({tag, ".a_hold"}, A, old_a);
      check({tag, ".b_hold"}, B, old_b);
    end
  endtask

  initial begin
    int n0, rel_cyc;
    int ps[3];
    int pe[3];
    logic [2:0] mask;

    reset = 1'b1;
    BtnUC = 3'b111;
    SwA   = 4'h5;
    SwB   = 4'h6;
    step(3);
    check("rst.alu", ALUControl, 0);
    check("rst.a", A, 0);
    check("rst.b", B, 0);
    check("rst.strobe", op_strobe, 0);
    reset = 1'b0;
    step(4);
    check("rst.no_strobe", n_strobe, 0);

    run_pattern("single_b0", 0, 10, -1, -1, -1, -1, 4'h1, 4'h2);
    run_pattern("chord_b0b2", 0, 14, -1, -1, 6, 20, 4'h7, 4'h8);
    run_pattern("short_b1", -1, -1, 0, 3, -1, -1, 4'h9, 4'h4);
    run_pattern("sw_sample", -1, -1, 0, 8, -1, -1, 4'hA, 4'h3);

    SwA = 4'hF;
    SwB = 4'h0;
    step(10);
    check("sw_hold.a", A, 4'hA);
    check("sw_hold.b", B, 4'h3);
    check("sw_hold.alu", ALUControl, 3'b010);

    // reset while collecting, release before a fresh debounce
    n0 = n_strobe;
    BtnUC = 3'b110;
    step(10);
    reset = 1'b1;
    step(2);
    check("abort.rst_alu", ALUControl, 0);
    check("abort.rst_a", A, 0);
    reset = 1'b0;
    step(1);
    BtnUC = 3'b111;
    step(14);
    check("abort.strobes", n_strobe - n0, 0);
    check("abort.alu", ALUControl, 0);
    check("abort.a", A, 0);
    check("abort.b", B, 0);
    run_pattern("after_abort", -1, -1, 0, 9, -1, -1, 4'h5, 4'h9);

    // button held across reset is re-debounced and commits
    n0 = n_strobe;
    SwA = 4'hC;
    SwB = 4'hD;
    BtnUC = 3'b011;
    step(3);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(12);
    rel_cyc = cyc;
    BtnUC = 3'b111;
    step(LAT + 5);
    check("held_rst.strobes", n_strobe - n0, 1);
    check("held_rst.latency", last_strobe - rel_cyc, LAT);
    check("held_rst.alu", ALUControl, 3'b100);
    check("held_rst.a", A, 4'hC);

    for (int t = 0; t < 24; t++) begin
      mask = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
        if (mask[i]) begin
          ps[i] = int'($urandom_range(0, 3));
          pe[i] = int'($urandom_range(12, 20));
        end else if ($urandom_range(0, 1) == 1) begin
          ps[i] = int'($urandom_range(0, 15));
          pe[i] = ps[i] + int'($urandom_range(1, DB - 1));
        end else begin
          ps[i] = -1;
          pe[i] = -1;
        end
      end
      run_pattern($sformatf("rand%0d", t),
                  ps[0], pe[0], ps[1], pe[1], ps[2], pe[2],
                  W'($urandom), W'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_input_conditioner.md
ALU_INPUT_CONDITIONER -- requirements
Module: alu_input_conditioner

Interface
REQ-001 Parameter: WIDTH, 4, operand width in bits.
REQ-002 Parameter: DB_CYCLES, 50000, consecutive stable cycles a button must hold before its debounced level changes; legal range is 2 or more.
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: BtnUC  input  3  raw push buttons, active-low, asynchronous to clk.
REQ-006 Port: SwA  input  WIDTH  raw operand-A switches, asynchronous.
REQ-007 Port: SwB  input  WIDTH  raw operand-B switches, asynchronous.
REQ-008 Port: ALUControl  output  3  registered opcode for the downstream ALU.
REQ-009 Port: A  output  WIDTH  registered operand A.
REQ-010 Port: B  output  WIDTH  registered operand B.
REQ-011 Port: op_strobe  output  1  one-cycle pulse marking a new committed operation.

Function
REQ-012 The block SHALL pass BtnUC, SwA and SwB through a 2-flop synchronizer each; BtnUC SHALL be inverted after synchronization so that 1 means pressed.
REQ-013 Each button SHALL have an independent debouncer: counter increments while synced level differs from debounced level, clears on any match.
REQ-014 The debounced level SHALL toggle on the edge where the counter reaches DB_CYCLES-1; the counter SHALL then clear, and it SHALL saturate without wrapping.
REQ-015 Pulses shorter than DB_CYCLES synced cycles SHALL have no effect on the debounced level.
REQ-016 The FSM SHALL have the states IDLE, COLLECT and COMMIT.
REQ-017 FSM IDLE: when the debounced vector is nonzero, go to COLLECT and load chord register = debounced vector.
REQ-018 FSM COLLECT: chord register |= debounced vector every cycle; when the debounced vector is all-zero, go to COMMIT.
REQ-019 FSM COMMIT (exactly one cycle): ALUControl <= chord, A <= synced SwA, B <= synced SwB, op_strobe = 1; then go to IDLE unconditionally.
REQ-020 op_strobe SHALL be high only in COMMIT; back-to-back commits are impossible because a new press needs at least DB_CYCLES cycles.
REQ-021 ALUControl, A and B SHALL hold their values between commits regardless of switch or button activity.
REQ-022 Latency from the first raw release edge of the last held button to op_strobe high SHALL be 2 + DB_CYCLES + 1 cycles (fixed).
REQ-023 Switches SHALL NOT be debounced; the value sampled is the synced value on the COMMIT cycle only.
REQ-024 A chord of overlapping presses SHALL commit the OR of all buttons seen in COLLECT (e.g. bit0 then bit2 gives 3'b101).

Reset
REQ-025 While reset is high: ALUControl=0, A=0, B=0, op_strobe=0, FSM=IDLE, chord=0, all debounce counters=0, debounced levels=released, synchronizer flops=released/0.
REQ-026 Reset SHALL take priority over every FSM transition; reset during COLLECT or COMMIT SHALL abort the operation without a strobe.
REQ-027 Buttons held through reset deassertion SHALL be debounced afresh and SHALL commit normally on release.

Structure
REQ-028 Package alu_input_pkg SHALL hold the FSM state enum (IDLE, COLLECT, COMMIT) and the default DB_CYCLES constant.
REQ-029 The single sub-module debounce_cell (1-bit input, DB_CYCLES parameter, clk, reset) SHALL be instantiated 3 times; all other logic stays in alu_input_conditioner.

Verification (DB_CYCLES=4)
REQ-030 Scenario: BtnUC[0] low for 10 cycles then high -> one op_strobe exactly 2+4+1 cycles after the release; ALUControl=3'b001.
REQ-031 Scenario: BtnUC[0] low, BtnUC[2] low 6 cycles later, both released in turn -> single strobe; ALUControl=3'b101.
REQ-032 Scenario: BtnUC[1] low for 3 cycles -> no strobe; ALUControl unchanged.
REQ-033 Scenario: SwA=4'hA, SwB=4'h3 held, press/release BtnUC[1], then SwA=4'hF -> after strobe A=4'hA, B=4'h3, ALUControl=3'b010, and A stays 4'hA afterward.
REQ-034 Scenario: reset pulsed while in COLLECT, then buttons released -> all outputs 0 and no strobe; a fresh press/release commits normally.
